// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: loads operands on start/ready, applies controller
// add/sh/done strobes to {C,A,Q}, and holds the product on a valid/ack port.
module mult_datapath #(
  parameter int WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [WIDTH-1:0]     x_in,
  input  logic [WIDTH-1:0]     y_in,
  output logic                 ready_out,
  input  logic                 add,
  input  logic                 sh,
  input  logic                 done,
  output logic                 m,
  output logic                 adx,
  output logic [2*WIDTH-1:0]   product_out,
  output logic                 valid_out,
  input  logic                 ack_in
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               valid_q, valid_d;
  logic [WIDTH:0]     sum;

  assign ready_out   = (state_q == S_IDLE);
  assign adx         = (state_q == S_RUN);
  assign m           = q_q[0];
  assign product_out = p_q;
  assign valid_out   = valid_q;

  always_comb begin
    // NOTE: every signal assigned here gets a hold default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    b_d     = b_q;
    c_d     = c_q;
    a_d     = a_q;
    q_d     = q_q;
    p_d     = p_q;
    valid_d = valid_q;
    sum     = {1'b0, a_q} + {1'b0, b_q};

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          b_d     = x_in;
          q_d     = y_in;
          a_d     = '0;
          c_d     = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The carry out of A+B lands in C, and a shift moves it into A's MSB.
        case ({add, sh})
          2'b10:   {c_d, a_d}      = sum;
          2'b01:   {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
          2'b11:   {c_d, a_d, q_d} = {1'b0, sum, q_q[WIDTH-1:1]};
          default: ;
        endcase
        if (done) begin
          p_d     = {a_d, q_d};
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ack_in) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      c_q     <= c_d;
      a_q     <= a_d;
      q_q     <= q_d;
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_mult_datapath.sv
// Directed and randomized bench for mult_datapath; the bench acts as the controller
// and compares against plain arithmetic (product = x*y, m after k shifts = y[k]).
module tb_mult_datapath;

  localparam int W = 4;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           start_in;
  logic [W-1:0]   x_in;
  logic [W-1:0]   y_in;
  logic           ready_out;
  logic           add;
  logic           sh;
  logic           done;
  logic           m;
  logic           adx;
  logic [2*W-1:0] product_out;
  logic           valid_out;
  logic           ack_in;

  int errors = 0;
  int checks = 0;

  mult_datapath #(.WIDTH(W)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .ready_out   (ready_out),
    .add         (add),
    .sh          (sh),
    .done        (done),
    .m           (m),
    .adx         (adx),
    .product_out (product_out),
    .valid_out   (valid_out),
    .ack_in      (ack_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 16'(ready_out), 16'd1);
    check({tag, "_adx"},   16'(adx),       16'd0);
    check({tag, "_valid"}, 16'(valid_out), 16'd0);
  endtask

  // Load operands and act as the controller. concurrent=1 issues add+sh together
  // and merges done into the last shift; ack_early raises ack_in before HOLD.
  task automatic run_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit concurrent, input bit ack_early);
    int exp_p;
    exp_p = int'(x) * int'(y);
    x_in = x; y_in = y; start_in = 1'b1;
    check("load_ready", 16'(ready_out), 16'd1);
    step();
    start_in = 1'b0;
    check("run_adx",   16'(adx),       16'd1);
    check("run_ready", 16'(ready_out), 16'd0);
    for (int k = 0; k < W; k++) begin
      check("m_bit", 16'(m), 16'(y[k]));
      if (concurrent) begin
        add = y[k]; sh = 1'b1;
        if (k == W - 1) begin
          done = 1'b1;
          ack_in = ack_early;
        end
        step();
      end else begin
        if (y[k]) begin
          add = 1'b1; step(); add = 1'b0;
          check("m_after_add", 16'(m), 16'(y[k]));
        end
        sh = 1'b1; step();
      end
      add = 1'b0; sh = 1'b0;
    end
    if (!concurrent) begin
      done = 1'b1; ack_in = ack_early; step();
    end
    done = 1'b0;
    check("done_valid",   16'(valid_out),   16'd1);
    check("done_product", 16'(product_out), 16'(exp_p));
    check("done_adx",     16'(adx),         16'd0);
    check("done_ready",   16'(ready_out),   16'd0);
    if (ack_early) begin
      step();
      ack_in = 1'b0;
      check("early_ack_valid", 16'(valid_out), 16'd0);
      check("early_ack_ready", 16'(ready_out), 16'd1);
    end
  endtask

  task automatic do_ack();
    ack_in = 1'b1; step(); ack_in = 1'b0;
    check_idle("ack");
  endtask

  initial begin
    logic [W-1:0]   rx, ry;
    logic [2*W-1:0] held_p;
    logic           held_m;

    rst_in = 1'b1; start_in = 1'b0; x_in = '0; y_in = '0;
    add = 1'b0; sh = 1'b0; done = 1'b0; ack_in = 1'b0;
    #1;
    check_idle("reset");
    check("reset_m",       16'(m),           16'd0);
    check("reset_product", 16'(product_out), 16'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();

    // Basic multiply 11*13, separate add/shift cycles.
    run_mult(4'b1011, 4'b1101, 1'b0, 1'b0);
    do_ack();

    // Carry path 15*15.
    run_mult(4'b1111, 4'b1111, 1'b0, 1'b0);
    do_ack();

    // Concurrent add+sh, done with the last shift, ack already high.
    run_mult(4'b0110, 4'b0011, 1'b1, 1'b1);

    // Zero multiplicand, then strobes in IDLE must be ignored.
    run_mult(4'b0000, 4'b1010, 1'b0, 1'b0);
    do_ack();
    held_m = m;
    held_p = product_out;
    add = 1'b1; sh = 1'b1; done = 1'b1;
    repeat (3) step();
    add = 1'b0; sh = 1'b0; done = 1'b0;
    check_idle("idle_strobes");
    check("idle_strobes_m",       16'(m),           16'(held_m));
    check("idle_strobes_product", 16'(product_out), 16'(held_p));

    // Backpressure: result held, new start ignored while in HOLD.
    run_mult(4'b0101, 4'b0111, 1'b0, 1'b0);
    x_in = 4'b1111; y_in = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      start_in = (i == 2);
      step();
      check("bp_valid",   16'(valid_out),   16'd1);
      check("bp_product", 16'(product_out), 16'd35);
      check("bp_ready",   16'(ready_out),   16'd0);
    end
    start_in = 1'b0;
    do_ack();
    step();
    check_idle("bp_no_queue");

    // Reset mid-RUN after two shifts.
    x_in = 4'd7; y_in = 4'd9; start_in = 1'b1; step(); start_in = 1'b0;
    add = 1'b1; step(); add = 1'b0;
    sh = 1'b1; step(); step(); sh = 1'b0;
    rst_in = 1'b1;
    #1;
    check_idle("rst_run");
    check("rst_run_m",       16'(m),           16'd0);
    check("rst_run_product", 16'(product_out), 16'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();
    check_idle("after_rst");
    run_mult(4'd7, 4'd9, 1'b0, 1'b0);
    do_ack();

    // Random operands in both controller styles.
    for (int i = 0; i < 20; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      run_mult(rx, ry, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) step();
      do_ack();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Shift-add multiplier datapath paired with `mult_controler`. Accepts an operand pair through a start/ready handshake and holds multiplicand, multiplier and partial-product registers. Drives the controller's `m` (current multiplier bit) and `adx` (operation active) inputs, and applies the controller's `add`/`sh`/`done` strobes. Presents the finished product on a valid/ack output port and holds it until the consumer accepts it.

## Interface
- `WIDTH`, default 4, operand width in bits; product is 2*WIDTH bits.

- `clk_in`  in  1  single clock, rising edge
- `rst_in`  in  1  asynchronous, active-high reset
- `start_in`  in  1  operand-load request; honoured only while `ready_out`=1
- `x_in`  in  WIDTH  multiplicand, unsigned
- `y_in`  in  WIDTH  multiplier, unsigned
- `ready_out`  out  1  datapath idle, operands accepted this cycle if `start_in`=1
- `add`  in  1  controller strobe: add multiplicand into accumulator
- `sh`  in  1  controller strobe: shift {carry, accumulator, multiplier} right by 1
- `done`  in  1  controller strobe: multiplication complete
- `m`  out  1  LSB of multiplier register, to controller
- `adx`  out  1  high while an operation is in progress, to controller
- `product_out`  out  2*WIDTH  result, valid when `valid_out`=1
- `valid_out`  out  1  result available
- `ack_in`  in  1  consumer accepts result

## Operation
- State machine: IDLE, RUN, HOLD.
- Registers: B (WIDTH, multiplicand), C (1, carry), A (WIDTH, accumulator), Q (WIDTH, multiplier), P (2*WIDTH, product output).
- IDLE: `ready_out`=1. If `start_in`=1, then B<=`x_in`, Q<=`y_in`, A<=0, C<=0, and the state goes to RUN.
- RUN: `adx`=1. The per-cycle update depends on the strobes:
  - `add` only: {C,A} <= A + B (WIDTH+1-bit sum).
  - `sh` only: {C,A,Q} <= {0,C,A,Q[WIDTH-1:1]}.
  - `add` and `sh` together: add first, then shift the sum in the same edge. {C,A,Q} <= {0, (A+B), Q[WIDTH-1:1]}.
  - Neither: hold.
- RUN with `done`=1: P <= {A,Q} after that cycle's add/shift is applied. `valid_out`<=1 and the state goes to HOLD.
- HOLD: P and `valid_out` stay stable. `ack_in`=1 clears `valid_out` and moves to IDLE.
- `m` = Q[0] in every state. The controller therefore sees the next multiplier bit one cycle after each shift.
- Strobes outside RUN (`add`, `sh`, `done`) are ignored. `start_in` outside IDLE is ignored, with no queuing.
- Carry out of A+B is never lost: C receives it and the following shift moves it into A[WIDTH-1].
- All arithmetic is unsigned. The product is exact for all 2^(2*WIDTH) operand pairs.

## Timing
- Reset (asynchronous, immediate): state=IDLE, B=C=A=Q=P=0, `ready_out`=1, `adx`=0, `m`=0, `valid_out`=0, `product_out`=0.
- `start_in` accepted at edge k: `adx`=1 and `ready_out`=0 from k+1, and `m`=`y_in`[0] from k+1.
- Each strobe takes effect at the edge where it is sampled. `m` reflects the result from the following cycle.
- `done` sampled at edge j: `valid_out`=1 and `product_out` valid from j+1, `adx`=0 from j+1.
- `ack_in` sampled high at edge h (in HOLD): `valid_out`=0 and `ready_out`=1 from h+1. A new start can be accepted at edge h+1.
- If `ack_in` is already high when HOLD is entered, the result is consumed at the first HOLD edge, so `valid_out` is high for exactly one cycle.
- `ack_in` while not in HOLD: ignored.
- Minimum operand-to-operand period is WIDTH shift cycles plus load, done and ack cycles. The controller sets the actual count.
- Reset asserted mid-RUN or mid-HOLD aborts the operation and discards the result. The block is IDLE the cycle after reset deasserts.

## Test plan
- Basic multiply: x=1011, y=1101, bench emulates the controller (add when m=1, then sh, four times, then done) -> `product_out`=10001111 (143), `valid_out`=1.
- Carry path: x=1111, y=1111 -> `product_out`=11100001 (225). C must be set after at least one add.
- Concurrent add+sh each cycle: x=0110, y=0011 -> `product_out`=00010010 (18), same result as the separate-cycle sequence.
- Zero and ignored strobes: x=0000, y=1010 gives `product_out`=0. `add`/`sh`/`done` pulsed in IDLE leave A, Q and `valid_out` unchanged.
- Backpressure: hold `ack_in`=0 for 5 cycles after `valid_out` and pulse `start_in` with new operands -> P stable, `ready_out`=0, start ignored. `ack_in`=1 gives IDLE the next cycle.
- Reset mid-RUN after 2 shifts -> next cycle all outputs at reset values. A fresh multiply of 7×9 then yields 63.
